mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the processor's data-memory bus, parallel to the data RAM.
- Stores to TX_ADDR push a byte into a FIFO; an FSM serializes bytes 8N1 on `tx`.
- A status word at STATUS_ADDR is readable through the same bus.
- The top level muxes `read_data` into the write-back path when `hit`=1.

---
 rtl/mmio_uart_tx_if.sv | 29 ++
 rtl/mmio_uart_tx.sv | 218 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-memory bus bundle between the core and the MMIO UART transmitter
//
// Purpose: groups the load/store signals the core presents to memory-mapped
// peripherals, together with the peripheral's read-back path.
// Signals:
//   address    32  ALU-computed data address (master -> slave)
//   write_data 32  store data (master -> slave)
//   MemWrite    1  store strobe (master -> slave)
//   MemRead     1  load strobe (master -> slave)
//   read_data  32  peripheral read data, 0 when not addressed (slave -> master)
//   hit         1  peripheral claims the current access (slave -> master)
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output address, write_data, MemWrite, MemRead,
    input  read_data, hit
  );

  modport slave (
    input  address, write_data, MemWrite, MemRead,
    output read_data, hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word
//
// Purpose: stores to TX_ADDR push a byte into a FIFO; an FSM serializes the
// bytes LSB first on tx. STATUS_ADDR returns
// {26'b0, parity_present, overflow, full, empty, busy, 1'b0}; a store there
// with bit 0 set clears the sticky overflow flag.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of mmio_uart_tx_if (address, write_data, MemWrite,
//          MemRead in; read_data, hit out)
//   tx     out  serial line, idle high
//   irq    out  registered: FIFO empty and FSM idle
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0080,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_0084
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_addr_tx;
  logic w_addr_st;
  logic w_push;
  logic w_ctrl_clr;
  logic w_empty;
  logic w_full;
  logic w_busy;
  logic w_pop;
  logic w_push_ok;
  logic w_ovf_set;
  logic w_bit_done;
  logic [7:0] w_head;

  assign w_addr_tx  = (bus.address == TX_ADDR);
  assign w_addr_st  = (bus.address == STATUS_ADDR);
  assign w_push     = bus.MemWrite & w_addr_tx;
  assign w_ctrl_clr = bus.MemWrite & w_addr_st & bus.write_data[0];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_busy     = (r_state != S_IDLE);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_done = (r_baud == BAUD_MAX);

  // The FSM pops only from IDLE, so a byte stored while idle leaves on the next edge.
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_ovf_set  = w_push & w_full & ~w_pop;

  assign bus.hit = (bus.MemRead | bus.MemWrite) & (w_addr_tx | w_addr_st);

  always_comb begin
    bus.read_data = '0;
    if (bus.MemRead && w_addr_st) begin
      bus.read_data = {26'b0, PARITY_PRESENT, r_overflow, w_full, w_empty, w_busy, 1'b0};
    end
  end

  // FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A new overflow on the same edge as a clear takes priority.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ctrl_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: if (w_bit_done) w_next = S_DATA;
      S_DATA: begin
        if (w_bit_done && r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_done) w_next = S_STOP;
`endif
      S_STOP:  if (w_bit_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Baud counter, bit index and shift register. The index wraps 7 -> 0 on
  // leaving DATA, so it is already 0 for the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_pop) begin
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
      r_parity <= ^w_head;
`endif
    end else if (r_state != S_IDLE) begin
      if (w_bit_done) begin
        r_baud <= '0;
        if (r_state == S_DATA) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_idx   <= r_idx + 3'd1;
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (r_state)
      S_IDLE:   tx = 1'b1;
      S_START:  tx = 1'b0;
      S_DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = r_parity;
`endif
      S_STOP:   tx = 1'b1;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq <= 1'b1;
    end else begin
      irq <= w_empty & (r_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          NB = 11;
  localparam logic [31:0] PB = 32'h20;
`else
  localparam int          NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic irq;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_clear();
    bus.address    = '0;
    bus.write_data = '0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.address = 32'h84;
    bus.MemRead = 1'b1;
    #1;
    v = bus.read_data;
    bus.MemRead = 1'b0;
    bus.address = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.address    = a;
    bus.write_data = d;
    bus.MemWrite   = 1'b1;
    @(posedge clock);
    #1;
    bus_clear();
  endtask

  // Expected tx at the negedge after store edge N+j, frame starting at edge N+1.
  function automatic logic exp_tx(input logic [7:0] b, input int j);
    if (j < 1) return 1'b1;
    if (j <= 4) return 1'b0;
    if (j <= 36) return b[(j - 5) / 4];
`ifdef UART_TX_PARITY_EN
    if (j <= 40) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits for a start bit, samples each bit mid-cell and checks the byte.
  task automatic capture(input logic [7:0] exp, input string name, output int start);
    logic       found;
    logic [7:0] got;
    found = 1'b0;
    start = -1;
    got   = '0;
    for (int w = 0; w < 200 && !found; w++) begin
      @(negedge clock);
      if (tx === 1'b0) found = 1'b1;
    end
    chk($sformatf("%s start", name), {31'b0, found}, 32'h1);
    if (!found) return;
    start = cyc;
    repeat (5) @(negedge clock);
    got[0] = tx;
    for (int i = 1; i < 8; i++) begin
      repeat (4) @(negedge clock);
      got[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (4) @(negedge clock);
    chk($sformatf("%s parity", name), {31'b0, tx}, {31'b0, ^exp});
`endif
    repeat (4) @(negedge clock);
    chk($sformatf("%s stop", name), {31'b0, tx}, 32'h1);
    chk($sformatf("%s data", name), {24'b0, got}, {24'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int st [6];
    int lows;
    int dummy;

    vt[0] = '{32'h84,  32'h0, 1'b0, 1'b1, 1'b1, 32'h4 | PB};
    vt[1] = '{32'h80,  32'h0, 1'b0, 1'b1, 1'b1, 32'h0};
    vt[2] = '{32'h88,  32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[3] = '{32'h84,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[4] = '{32'h84,  32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
    vt[5] = '{32'h80,  32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
    vt[6] = '{32'h184, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[7] = '{32'h84,  32'h0, 1'b1, 1'b1, 1'b1, 32'h4 | PB};

    bus_clear();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset tx", {31'b0, tx}, 32'h1);
    chk("reset irq", {31'b0, irq}, 32'h1);
    read_status(v);
    chk("reset status", v, 32'h4 | PB);

    // Decode vectors: strobes are applied and removed within one low phase.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.address    = vt[i].addr;
      bus.write_data = vt[i].wdata;
      bus.MemWrite   = vt[i].we;
      bus.MemRead    = vt[i].re;
      #1;
      chk($sformatf("vec%0d hit", i), {31'b0, bus.hit}, {31'b0, vt[i].exp_hit});
      chk($sformatf("vec%0d rdata", i), bus.read_data, vt[i].exp_rd);
      bus_clear();
    end

    // Single frame, cycle-exact.
    store(32'h80, 32'hFFFF_FF55);
    for (int j = 0; j <= NB * CPB + 2; j++) begin
      @(negedge clock);
      chk($sformatf("frame55 tx j=%0d", j), {31'b0, tx}, {31'b0, exp_tx(8'h55, j)});
      if (j == 0) chk("frame55 irq j=0", {31'b0, irq}, 32'h1);
      if (j == 1) chk("frame55 irq j=1", {31'b0, irq}, 32'h0);
      if (j == 2) begin
        read_status(v);
        chk("frame55 busy status", v, 32'h6 | PB);
      end
      if (j == NB * CPB + 1) chk("frame55 irq before", {31'b0, irq}, 32'h0);
      if (j == NB * CPB + 2) chk("frame55 irq after", {31'b0, irq}, 32'h1);
    end

    // Six back-to-back stores: 0x06 overflows.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clock);
          bus.address    = 32'h80;
          bus.write_data = {24'hABCDEF, 8'(k + 1)};
          bus.MemWrite   = 1'b1;
        end
        @(posedge clock);
        #1;
        bus_clear();
        read_status(v);
        chk("burst overflow status", v, 32'h1A | PB);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          capture(8'(k + 1), $sformatf("burst%0d", k + 1), st[k]);
        end
      end
    join
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("burst spacing %0d", k), st[k + 1] - st[k], NB * CPB + 1);
    end
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("burst no sixth frame", lows, 0);
    read_status(v);
    chk("burst idle status", v, 32'h14 | PB);
    chk("burst irq", {31'b0, irq}, 32'h1);

    // Overflow clear control.
    store(32'h84, 32'h0000_0000);
    @(negedge clock);
    read_status(v);
    chk("clear bit0=0 keeps ovf", v, 32'h14 | PB);
    store(32'h84, 32'hFFFF_FFF1);
    @(negedge clock);
    read_status(v);
    chk("clear bit0=1", v, 32'h4 | PB);

    // Push into full FIFO on the pop edge.
    fork
      begin
        @(negedge clock);
        bus.address = 32'h80; bus.write_data = 32'h11; bus.MemWrite = 1'b1;
        @(negedge clock); bus.write_data = 32'h22;
        @(negedge clock); bus.write_data = 32'h33;
        @(negedge clock); bus.write_data = 32'h44;
        @(negedge clock); bus.write_data = 32'hC3;
        @(negedge clock);
        bus_clear();
        repeat (NB * CPB - 3) @(negedge clock);
        read_status(v);
        chk("full idle before pop", v, 32'h8 | PB);
        bus.address = 32'h80; bus.write_data = 32'h5A; bus.MemWrite = 1'b1;
        @(posedge clock);
        #1;
        bus_clear();
        read_status(v);
        chk("push on pop accepted", v, 32'hA | PB);
      end
      begin
        capture(8'h11, "pp11", st[0]);
        capture(8'h22, "pp22", st[1]);
        capture(8'h33, "pp33", st[2]);
        capture(8'h44, "pp44", st[3]);
        capture(8'hC3, "ppC3", st[4]);
        capture(8'h5A, "pp5A", st[5]);
      end
    join
    repeat (3) @(negedge clock);
    read_status(v);
    chk("push on pop no ovf", v, 32'h4 | PB);

    // Reset during DATA bit 3 of 0xA5.
    store(32'h80, 32'hA5);
    repeat (19) @(negedge clock);
    chk("A5 bit3 before reset", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("reset edge tx", {31'b0, tx}, 32'h1);
    reset = 1'b0;
    @(negedge clock);
    chk("after abort irq", {31'b0, irq}, 32'h1);
    read_status(v);
    chk("after abort status", v, 32'h4 | PB);
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("after abort line idle", lows, 0);

    // Parity-sensitive bytes (parity bit checked when the feature is built in).
    store(32'h80, 32'h07);
    capture(8'h07, "par07", dummy);
    store(32'h80, 32'h03);
    capture(8'h03, "par03", dummy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
